// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) from uart_rxd and presents each
// completed word in a one-entry output register with a valid/ready handshake.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            receiver enable; low aborts a frame in progress
//   uart_rxd      asynchronous serial input, idle high
//   data          received word
//   data_valid    data/frame_err/parity_err hold a word
//   data_ready    consumer accepts the word when data_valid && data_ready
//   frame_err     held word had a stop bit sampled low
//   parity_err    held word failed the parity check
//   overrun_err   one-cycle pulse when a completed frame is dropped
//   busy          receiver is inside a frame (any state but IDLE)

module uart_rx_cfg #(
    parameter int CLK_DIV     = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int H  = CLK_DIV / 2;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic [3:0]             bitn, bitn_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [DATA_BITS-1:0]   shreg;
    logic                   ferr_pend, perr_pend;

    logic start_clr;
    logic shift_en;
    logic par_chk;
    logic stop_chk;
    logic frame_done;

    // True when the data bits plus the received parity bit violate the
    // configured parity (odd: total ones must be odd; even: must be even).
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                        input logic pbit);
        logic ones_odd;
        ones_odd = (^d) ^ pbit;
        return (PARITY == 1) ? !ones_odd : ones_odd;
    endfunction

    // Input synchroniser: resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], uart_rxd};
        end
    end

    assign rxs  = sync[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    // State, bit timer and bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitn      <= '0;
            ferr_pend <= 1'b0;
            perr_pend <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            bitn  <= bitn_next;
            if (start_clr) begin
                ferr_pend <= 1'b0;
                perr_pend <= 1'b0;
            end
            if (par_chk) begin
                perr_pend <= parity_bad(shreg, rxs);
            end
            if (stop_chk && !rxs) begin
                ferr_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bitn_next  = bitn;
        start_clr  = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        stop_chk   = 1'b0;
        frame_done = 1'b0;

        if (!en) begin
            // Abort: the partial frame is simply forgotten; pending flags are
            // cleared when the next start bit is seen.
            state_next = IDLE;
            cnt_next   = '0;
            bitn_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next  = '0;
                    bitn_next = '0;
                    if (!rxs) begin
                        state_next = START;
                        start_clr  = 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        // Mid start bit: a high line here was a glitch.
                        cnt_next   = '0;
                        bitn_next  = '0;
                        state_next = rxs ? IDLE : DATA;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift_en = 1'b1;
                        cnt_next = '0;
                        if (bitn == DATA_LAST) begin
                            bitn_next  = '0;
                            state_next = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bitn_next = bitn + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (cnt == CNT_LAST) begin
                        par_chk    = 1'b1;
                        cnt_next   = '0;
                        bitn_next  = '0;
                        state_next = STOP;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        stop_chk = 1'b1;
                        cnt_next = '0;
                        if (bitn == STOP_LAST) begin
                            // Completing at mid stop bit leaves half a bit of
                            // slack for a following frame's start edge.
                            frame_done = 1'b1;
                            bitn_next  = '0;
                            state_next = IDLE;
                        end else begin
                            bitn_next = bitn + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    bitn_next  = '0;
                end
            endcase
        end
    end

    // Data shift register, LSB first: each new bit enters at the top.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
    end

    // One-entry output register with overrun detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!data_valid || data_ready) begin
                    data       <= shreg;
                    frame_err  <= ferr_pend | !rxs;
                    parity_err <= perr_pend;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: an 8N1 instance (a) and a 7-bit even-parity,
// two-stop-bit instance (b), both at 16 clocks per bit.

module tb_uart_rx_cfg;

    localparam int CD   = 16;
    localparam int H    = CD / 2;
    localparam int SYNC = 2;

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
        int         c;
    } cap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b, rxd_a, rxd_b, rdy_a, rdy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       dv_a, dv_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b, busy_a, busy_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   vhi_a = 0;
    cap_t cap_a[$];
    cap_t cap_b[$];
    int   ovq_a[$];
    int   ovq_b[$];

    uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .uart_rxd(rxd_a), .data(data_a),
        .data_valid(dv_a), .data_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun_err(ovr_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(SYNC)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .uart_rxd(rxd_b), .data(data_b),
        .data_valid(dv_b), .data_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b),
        .overrun_err(ovr_b), .busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect accepted words and overrun pulses, sampled on the falling edge.
    always @(negedge clk) begin
        cap_t t;
        if (dv_a) vhi_a <= vhi_a + 1;
        if (dv_a && rdy_a) begin
            t.d = {1'b0, data_a}; t.fe = fe_a; t.pe = pe_a; t.c = cyc;
            cap_a.push_back(t);
        end
        if (dv_b && rdy_b) begin
            t.d = {2'b0, data_b}; t.fe = fe_b; t.pe = pe_b; t.c = cyc;
            cap_b.push_back(t);
        end
        if (ovr_a) ovq_a.push_back(cyc);
        if (ovr_b) ovq_b.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame on the chosen line; e returns the cycle the start bit began.
    task automatic send_frame(input int which, input logic [8:0] d, input int nd,
                              input int par, input logic pbit, input logic [1:0] stopv,
                              input int ns, output int e);
        logic [15:0] fr;
        int n;
        fr = '1;
        n = 0;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < nd; i++) begin fr[n] = d[i]; n++; end
        if (par != 0) begin fr[n] = pbit; n++; end
        for (int i = 0; i < ns; i++) begin fr[n] = stopv[i]; n++; end
        e = cyc;
        for (int i = 0; i < n; i++) begin
            if (which == 0) rxd_a = fr[i]; else rxd_b = fr[i];
            step(CD);
        end
        if (which == 0) rxd_a = 1'b1; else rxd_b = 1'b1;
    endtask

    // Reference: expected word, flags and delivery cycle from the frame contents.
    function automatic cap_t expect_frame(input logic [8:0] d, input int nd, input int par,
                                          input logic pbit, input logic [1:0] stopv,
                                          input int ns, input int e);
        cap_t r;
        int ones, nbits;
        r.d   = d & ((9'h1 << nd) - 9'h1);
        ones  = $countones(r.d) + (pbit ? 1 : 0);
        r.pe  = (par == 2) ? (ones % 2 != 0) : (par == 1) ? (ones % 2 == 0) : 1'b0;
        r.fe  = (stopv[0] == 1'b0) || (ns == 2 && stopv[1] == 1'b0);
        nbits = nd + ((par != 0) ? 1 : 0) + ns;
        r.c   = e + SYNC + H + nbits * CD + 1;
        return r;
    endfunction

    task automatic test_reset;
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data_a got %h exp 00", data_a); end
        checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b exp 0", dv_a); end
        checks++; if (fe_a !== 1'b0 || pe_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b%b exp 00", fe_a, pe_a); end
        checks++; if (ovr_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL reset_ovr_busy_a got %b%b exp 00", ovr_a, busy_a); end
        checks++; if (data_b !== 7'h00 || dv_b !== 1'b0) begin errors++; $display("FAIL reset_b got %h/%b exp 00/0", data_b, dv_b); end
        checks++; if (fe_b !== 1'b0 || pe_b !== 1'b0 || ovr_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_flags_b got %b%b%b%b exp 0000", fe_b, pe_b, ovr_b, busy_b);
        end
    endtask

    task automatic test_basic;
        int e, v0;
        cap_t x;
        cap_a.delete();
        v0 = vhi_a;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, e);
        step(4);
        x = expect_frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1, e);
        checks++;
        if (cap_a.size() != 1) begin
            errors++; $display("FAIL basic_count got %0d exp 1", cap_a.size());
        end else begin
            checks++; if (cap_a[0].d !== x.d) begin errors++; $display("FAIL basic_data got %h exp %h", cap_a[0].d, x.d); end
            checks++; if (cap_a[0].fe !== 1'b0 || cap_a[0].pe !== 1'b0) begin errors++; $display("FAIL basic_flags got %b%b exp 00", cap_a[0].fe, cap_a[0].pe); end
            checks++; if (cap_a[0].c != x.c) begin errors++; $display("FAIL basic_time got %0d exp %0d", cap_a[0].c, x.c); end
        end
        checks++; if (vhi_a - v0 != 1) begin errors++; $display("FAIL basic_valid_width got %0d exp 1", vhi_a - v0); end
    endtask

    task automatic test_parity;
        int e;
        cap_t x;
        for (int p = 0; p < 2; p++) begin
            cap_b.delete();
            send_frame(1, 9'h055, 7, 2, p[0], 2'b11, 2, e);
            step(4);
            x = expect_frame(9'h055, 7, 2, p[0], 2'b11, 2, e);
            checks++;
            if (cap_b.size() != 1) begin
                errors++; $display("FAIL parity_count pbit=%0d got %0d exp 1", p, cap_b.size());
            end else begin
                checks++; if (cap_b[0].d !== x.d) begin errors++; $display("FAIL parity_data got %h exp %h", cap_b[0].d, x.d); end
                checks++; if (cap_b[0].pe !== x.pe) begin errors++; $display("FAIL parity_err pbit=%0d got %b exp %b", p, cap_b[0].pe, x.pe); end
                checks++; if (cap_b[0].fe !== 1'b0) begin errors++; $display("FAIL parity_ferr got %b exp 0", cap_b[0].fe); end
                checks++; if (cap_b[0].c != x.c) begin errors++; $display("FAIL parity_time got %0d exp %0d", cap_b[0].c, x.c); end
            end
        end
    endtask

    task automatic test_frame;
        int e1, e2;
        cap_t x1, x2;
        cap_a.delete();
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1, e1);
        x1 = expect_frame(9'h03C, 8, 0, 1'b0, 2'b00, 1, e1);
        step(2 * CD);
        send_frame(0, 9'h001, 8, 0, 1'b0, 2'b11, 1, e2);
        x2 = expect_frame(9'h001, 8, 0, 1'b0, 2'b11, 1, e2);
        step(4);
        checks++;
        if (cap_a.size() != 2) begin
            errors++; $display("FAIL frame_count got %0d exp 2", cap_a.size());
        end else begin
            checks++; if (cap_a[0].d !== x1.d || cap_a[0].fe !== x1.fe) begin errors++; $display("FAIL frame_bad got %h/%b exp %h/%b", cap_a[0].d, cap_a[0].fe, x1.d, x1.fe); end
            checks++; if (cap_a[1].d !== x2.d || cap_a[1].fe !== x2.fe) begin errors++; $display("FAIL frame_clean got %h/%b exp %h/%b", cap_a[1].d, cap_a[1].fe, x2.d, x2.fe); end
        end
    endtask

    task automatic test_overrun;
        int e1, e2;
        cap_t x2;
        cap_a.delete();
        ovq_a.delete();
        rdy_a = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, e1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, e2);
        x2 = expect_frame(9'h022, 8, 0, 1'b0, 2'b11, 1, e2);
        step(2);
        checks++; if (dv_a !== 1'b1 || data_a !== 8'h11) begin errors++; $display("FAIL overrun_hold got %b/%h exp 1/11", dv_a, data_a); end
        checks++;
        if (ovq_a.size() != 1) begin
            errors++; $display("FAIL overrun_pulses got %0d exp 1", ovq_a.size());
        end else begin
            checks++; if (ovq_a[0] != x2.c) begin errors++; $display("FAIL overrun_time got %0d exp %0d", ovq_a[0], x2.c); end
        end
        rdy_a = 1'b1;
        step(1);
        checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL overrun_release got %b exp 0", dv_a); end
        checks++; if (cap_a.size() != 1 || cap_a[0].d !== 9'h011) begin errors++; $display("FAIL overrun_accept got n=%0d exp 1 word 011", cap_a.size()); end
    endtask

    task automatic test_glitch;
        int e;
        cap_a.delete();
        e = cyc;
        rxd_a = 1'b0;
        step(3);
        rxd_a = 1'b1;
        step(1);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b exp 1", busy_a); end
        step(e + SYNC + H + 1 - cyc);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b exp 0 at cyc %0d", busy_a, cyc); end
        step(3 * CD);
        checks++; if (cap_a.size() != 0) begin errors++; $display("FAIL glitch_output got %0d words exp 0", cap_a.size()); end
    endtask

    task automatic test_enable;
        int e1, e2;
        cap_t x;
        cap_a.delete();
        fork
            send_frame(0, 9'($urandom), 8, 0, 1'b0, 2'b11, 1, e1);
            begin
                step(60);
                en_a = 1'b0;
                step(1);
                checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL enable_abort_busy got %b exp 0", busy_a); end
            end
        join
        step(5);
        en_a = 1'b1;
        step(2);
        send_frame(0, 9'h07E, 8, 0, 1'b0, 2'b11, 1, e2);
        x = expect_frame(9'h07E, 8, 0, 1'b0, 2'b11, 1, e2);
        step(4);
        checks++;
        if (cap_a.size() != 1) begin
            errors++; $display("FAIL enable_count got %0d exp 1", cap_a.size());
        end else begin
            checks++; if (cap_a[0].d !== x.d || cap_a[0].fe !== 1'b0 || cap_a[0].pe !== 1'b0) begin
                errors++; $display("FAIL enable_word got %h/%b%b exp %h/00", cap_a[0].d, cap_a[0].fe, cap_a[0].pe, x.d);
            end
        end
    endtask

    task automatic test_random;
        cap_t expq[$];
        cap_t x;
        int e, which, nd, par, ns;
        logic [8:0] d;
        logic pbit;
        logic [1:0] stopv;
        for (int w = 0; w < 2; w++) begin
            which = w;
            nd    = (w == 0) ? 8 : 7;
            par   = (w == 0) ? 0 : 2;
            ns    = (w == 0) ? 1 : 2;
            expq.delete();
            cap_a.delete(); cap_b.delete(); ovq_a.delete(); ovq_b.delete();
            for (int i = 0; i < 6; i++) begin
                d     = 9'($urandom);
                pbit  = 1'($urandom);
                stopv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                send_frame(which, d, nd, par, pbit, stopv, ns, e);
                expq.push_back(expect_frame(d, nd, par, pbit, stopv, ns, e));
                // A low final stop bit looks like a new start edge; let it die out.
                if (stopv[ns-1] == 1'b0) step(2 * CD);
                else if ($urandom_range(0, 1) == 1) step($urandom_range(1, 4));
            end
            step(4);
            checks++;
            if (((w == 0) ? cap_a.size() : cap_b.size()) != expq.size()) begin
                errors++; $display("FAIL random_count dut=%0d got %0d exp %0d", w, (w == 0) ? cap_a.size() : cap_b.size(), expq.size());
            end else begin
                for (int i = 0; i < expq.size(); i++) begin
                    x = (w == 0) ? cap_a[i] : cap_b[i];
                    checks++;
                    if (x.d !== expq[i].d || x.fe !== expq[i].fe || x.pe !== expq[i].pe || x.c != expq[i].c) begin
                        errors++;
                        $display("FAIL random_word dut=%0d #%0d got %h fe%b pe%b @%0d exp %h fe%b pe%b @%0d",
                                 w, i, x.d, x.fe, x.pe, x.c, expq[i].d, expq[i].fe, expq[i].pe, expq[i].c);
                    end
                end
            end
            checks++;
            if (ovq_a.size() + ovq_b.size() != 0) begin errors++; $display("FAIL random_overrun got %0d exp 0", ovq_a.size() + ovq_b.size()); end
        end
    endtask

    task automatic test_rst_mid;
        int e;
        rdy_a = 1'b0;
        send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1, e);
        step(2);
        checks++; if (dv_a !== 1'b1 || data_a !== 8'h5A) begin errors++; $display("FAIL rst_mid_held got %b/%h exp 1/5a", dv_a, data_a); end
        rxd_a = 1'b0;
        step(40);
        rst = 1'b1;
        rxd_a = 1'b1;
        step(1);
        checks++; if (data_a !== 8'h00 || dv_a !== 1'b0) begin errors++; $display("FAIL rst_mid_word got %h/%b exp 00/0", data_a, dv_a); end
        checks++; if (busy_a !== 1'b0 || fe_a !== 1'b0 || pe_a !== 1'b0 || ovr_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags got %b%b%b%b exp 0000", busy_a, fe_a, pe_a, ovr_a);
        end
        rst = 1'b0;
        rdy_a = 1'b1;
        step(5);
    endtask

    initial begin
        rst   = 1'b1;
        en_a  = 1'b1;  en_b  = 1'b1;
        rxd_a = 1'b1;  rxd_b = 1'b1;
        rdy_a = 1'b1;  rdy_b = 1'b1;
        step(4);
        test_reset;
        rst = 1'b0;
        step(5);
        test_basic;
        test_parity;
        test_frame;
        test_overrun;
        test_glitch;
        test_enable;
        test_random;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
